// File: rtl/cpu_step_display.sv
// Step-button debouncer and 4-digit seven-segment scanner for the multi-cycle CPU board.
// Optional macro DISP_DP_EN lights the decimal point on digit 2 to split the two byte fields.
module cpu_step_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Btn,
    input  logic [1:0]  Sel,
    input  logic [31:0] PCOut,
    input  logic [31:0] PCIn,
    input  logic [4:0]  Rs,
    input  logic [31:0] RsData,
    input  logic [4:0]  Rt,
    input  logic [31:0] RtData,
    input  logic [31:0] ALUResult,
    input  logic [31:0] DB,
    output logic        Step,
    output logic [3:0]  AN,
    output logic [7:0]  Seg
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [15:0]       snap_q, snap_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic              stable_dly_q, stable_dly_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              step_q, step_d;

    logic [15:0]       disp_val_s;
    logic              scan_tick_s;
    logic [3:0]        nibble_s;
    logic              dp_s;
    logic              unused_s;

    // Active-low hex glyph for g..a; the dp bit is handled separately.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Only the low byte of each wide datapath value is displayed.
    assign unused_s = ^{PCOut[31:8], PCIn[31:8], RsData[31:8], RtData[31:8],
                        ALUResult[31:8], DB[31:8]};

    // Field selection for the value shown on the four digits.
    always_comb begin
        disp_val_s = 16'h0000;
        case (Sel)
            2'b00:   disp_val_s = {PCOut[7:0], PCIn[7:0]};
            2'b01:   disp_val_s = {3'b000, Rs, RsData[7:0]};
            2'b10:   disp_val_s = {3'b000, Rt, RtData[7:0]};
            2'b11:   disp_val_s = {ALUResult[7:0], DB[7:0]};
            default: disp_val_s = 16'h0000;
        endcase
    end

    // Scan timing; the snapshot is reloaded only as the scan returns to digit 3 so a frame is coherent.
    always_comb begin
        scan_tick_s = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = scan_cnt_q;
        digit_idx_d = digit_idx_q;
        snap_d      = snap_q;
        if (scan_tick_s) begin
            scan_cnt_d  = {SCAN_W{1'b0}};
            digit_idx_d = digit_idx_q - 2'd1;
            if (digit_idx_q == 2'd0) begin
                snap_d = disp_val_s;
            end else begin
                snap_d = snap_q;
            end
        end else begin
            scan_cnt_d = scan_cnt_q + {{(SCAN_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef DISP_DP_EN
    // Decimal point on digit 2 separates the upper and lower byte.
    always_comb begin
        if (digit_idx_q == 2'd2) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
    end
`else
    assign dp_s = 1'b1;
`endif

    // Digit enable and segment pattern for the digit currently being scanned.
    always_comb begin
        an_d     = 4'b1111;
        nibble_s = 4'h0;
        case (digit_idx_q)
            2'd3: begin an_d = 4'b0111; nibble_s = snap_q[15:12]; end
            2'd2: begin an_d = 4'b1011; nibble_s = snap_q[11:8];  end
            2'd1: begin an_d = 4'b1101; nibble_s = snap_q[7:4];   end
            2'd0: begin an_d = 4'b1110; nibble_s = snap_q[3:0];   end
            default: begin an_d = 4'b1111; nibble_s = 4'h0; end
        endcase
        seg_d = {dp_s, hex_glyph(nibble_s)};
    end

    // Button synchronizer, debounce counter and rising-edge step pulse.
    always_comb begin
        sync1_d      = Btn;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        step_d       = stable_q & ~stable_dly_q;
        stable_d     = stable_q;
        deb_cnt_d    = deb_cnt_q;
        if (sync2_q == stable_q) begin
            deb_cnt_d = {DEB_W{1'b0}};
        end else if (deb_cnt_q == DEB_LAST) begin
            stable_d  = sync2_q;
            deb_cnt_d = {DEB_W{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt_q   <= {SCAN_W{1'b0}};
            digit_idx_q  <= 2'd3;
            snap_q       <= 16'h0000;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            deb_cnt_q    <= {DEB_W{1'b0}};
            step_q       <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            snap_q       <= snap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            deb_cnt_q    <= deb_cnt_d;
            step_q       <= step_d;
        end
    end

    assign Step = step_q;
    assign AN   = an_q;
    assign Seg  = seg_q;

endmodule

// File: tb/tb_cpu_step_display.sv
// Self-checking bench for cpu_step_display: frame-arithmetic display model, sample-history
// debounce model, table-driven glyph vectors and hand sequences for the button corner cases.
module tb_cpu_step_display;

    localparam int SD  = 4;
    localparam int DEB = 8;

    logic        CLK = 1'b0;
    logic        RST, Btn;
    logic [1:0]  Sel;
    logic [31:0] PCOut, PCIn, RsData, RtData, ALUResult, DB;
    logic [4:0]  Rs, Rt;
    logic        Step;
    logic [3:0]  AN;
    logic [7:0]  Seg;

    cpu_step_display #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DEB)) dut (
        .CLK(CLK), .RST(RST), .Btn(Btn), .Sel(Sel),
        .PCOut(PCOut), .PCIn(PCIn), .Rs(Rs), .RsData(RsData),
        .Rt(Rt), .RtData(RtData), .ALUResult(ALUResult), .DB(DB),
        .Step(Step), .AN(AN), .Seg(Seg)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int step_count    = 0;
    int last_step_cyc = -1;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reference model state
    int         m_dn;
    logic [15:0] m_snap;
    logic       m_stable, m_rise;
    logic       hist[$];
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_step;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] pco, pci;
        logic [4:0]  rs;
        logic [31:0] rsd;
        logic [4:0]  rt;
        logic [31:0] rtd, alu, db;
        logic [31:0] exp_segs;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [15:0] v_ref();
        case (Sel)
            2'b00:   return {PCOut[7:0], PCIn[7:0]};
            2'b01:   return {3'b000, Rs, RsData[7:0]};
            2'b10:   return {3'b000, Rt, RtData[7:0]};
            default: return {ALUResult[7:0], DB[7:0]};
        endcase
    endfunction

    function automatic logic [7:0] dp_adj(input logic [7:0] s, input int idx);
        logic [7:0] r;
        r = s;
`ifdef DISP_DP_EN
        if (idx == 2) r[7] = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            m_dn = 0; m_snap = 16'h0000;
            e_an = 4'hF; e_seg = 8'hFF; e_step = 1'b0;
            hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
            m_stable = 1'b0; m_rise = 1'b0;
        end else begin
            int idx;
            logic [3:0] nib;
            logic all_diff;
            m_dn++;
            idx = 3 - (((m_dn - 1) / SD) % 4);
            e_an = 4'hF;
            e_an[idx] = 1'b0;
            nib = m_snap[idx*4 +: 4];
            e_seg = dp_adj(glyph[nib], idx);
            if (m_dn % (4 * SD) == 0) m_snap = v_ref();
            hist.push_back(Btn);
            e_step = m_rise;
            m_rise = 1'b0;
            if (hist.size() >= DEB + 2) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[hist.size() - 3 - j] == m_stable) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable = ~m_stable;
                    m_rise   = m_stable;
                end
            end
            while (hist.size() > 40) void'(hist.pop_front());
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        chk("AN", {28'h0, AN}, {28'h0, e_an});
        chk("Seg", {24'h0, Seg}, {24'h0, e_seg});
        chk("Step", {31'h0, Step}, {31'h0, e_step});
        if (Step === 1'b1) begin
            step_count++;
            last_step_cyc = cyc;
        end
    endtask

    task automatic wait_an(input logic [3:0] an, input string name);
        for (int i = 0; i < 8 * SD && AN !== an; i++) cycle();
        chk(name, {28'h0, AN}, {28'h0, an});
    endtask

    task automatic set_vec(input vec_t v);
        Sel = v.sel; PCOut = v.pco; PCIn = v.pci; Rs = v.rs; RsData = v.rsd;
        Rt = v.rt; RtData = v.rtd; ALUResult = v.alu; DB = v.db;
    endtask

    initial begin
        int s0, rel_c, rise_c;
        logic [31:0] got;
        vecs[0] = '{2'b00, 32'h14, 32'h18, 5'h00, 32'h0, 5'h00, 32'h0, 32'h0, 32'h0, 32'hF999F980};
        vecs[1] = '{2'b11, 32'h0, 32'h0, 5'h00, 32'h0, 5'h00, 32'h0, 32'hA5, 32'h3C, 32'h8892B0C6};
        vecs[2] = '{2'b01, 32'h0, 32'h0, 5'h1F, 32'h123EF, 5'h00, 32'h0, 32'h0, 32'h0, 32'hF98E868E};
        vecs[3] = '{2'b10, 32'h0, 32'h0, 5'h00, 32'h0, 5'h0B, 32'hFFD2, 32'h0, 32'h0, 32'hC083A1A4};
        vecs[4] = '{2'b00, 32'hAB67, 32'hCD90, 5'h00, 32'h0, 5'h00, 32'h0, 32'h0, 32'h0, 32'h82F890C0};

        RST = 1'b1; Btn = 1'b0; Sel = 2'b00; PCOut = 32'h0; PCIn = 32'h0;
        Rs = 5'h0; RsData = 32'h0; Rt = 5'h0; RtData = 32'h0; ALUResult = 32'h0; DB = 32'h0;

        // reset and first cycle after release
        repeat (3) cycle();
        chk("rst_AN", {28'h0, AN}, 32'hF);
        chk("rst_Seg", {24'h0, Seg}, 32'hFF);
        chk("rst_Step", {31'h0, Step}, 32'h0);
        RST = 1'b0;
        cycle();
        chk("first_AN", {28'h0, AN}, 32'h7);
        chk("first_Seg", {24'h0, Seg}, 32'hC0);

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            set_vec(vecs[v]);
            got = 32'h0;
            repeat (8 * SD) cycle();
            repeat (4 * SD) begin
                cycle();
                case (AN)
                    4'b0111: got[31:24] = Seg;
                    4'b1011: got[23:16] = Seg;
                    4'b1101: got[15:8]  = Seg;
                    4'b1110: got[7:0]   = Seg;
                    default: ;
                endcase
            end
            chk("vec_dig3", {24'h0, got[31:24]}, {24'h0, vecs[v].exp_segs[31:24]});
            chk("vec_dig2", {24'h0, got[23:16]}, {24'h0, dp_adj(vecs[v].exp_segs[23:16], 2)});
            chk("vec_dig1", {24'h0, got[15:8]},  {24'h0, vecs[v].exp_segs[15:8]});
            chk("vec_dig0", {24'h0, got[7:0]},   {24'h0, vecs[v].exp_segs[7:0]});
        end

        // Sel change mid-frame only shows from the next digit-3 slot
        set_vec(vecs[0]);
        ALUResult = 32'hA5; DB = 32'h3C;
        repeat (8 * SD) cycle();
        wait_an(4'b1101, "mid_wait1");
        Sel = 2'b11;
        chk("mid_dig1", {24'h0, Seg}, 32'hF9);
        wait_an(4'b1110, "mid_wait0");
        chk("mid_dig0", {24'h0, Seg}, 32'h80);
        wait_an(4'b0111, "mid_wait3");
        chk("new_dig3", {24'h0, Seg}, 32'h88);
        wait_an(4'b1011, "mid_wait2");
        chk("new_dig2", {24'h0, Seg}, {24'h0, dp_adj(8'h92, 2)});
        wait_an(4'b1101, "mid_wait1b");
        chk("new_dig1", {24'h0, Seg}, 32'hB0);
        wait_an(4'b1110, "mid_wait0b");
        chk("new_dig0", {24'h0, Seg}, 32'hC6);

        // bouncing button, then a clean hold
        s0 = step_count;
        for (int i = 0; i < 10; i++) begin
            Btn = (i % 2 == 0);
            repeat (3) cycle();
        end
        Btn = 1'b1;
        rise_c = cyc;
        repeat (30) cycle();
        chk("bounce_count", step_count - s0, 32'd1);
        chk("bounce_delay", last_step_cyc - rise_c, 32'd11);
        Btn = 1'b0;
        repeat (20) cycle();
        chk("release_count", step_count - s0, 32'd1);
        Btn = 1'b1;
        repeat (20) cycle();
        chk("repress_count", step_count - s0, 32'd2);
        Btn = 1'b0;
        repeat (20) cycle();

        // reset mid-count discards the partial count
        Btn = 1'b1;
        s0 = step_count;
        repeat (5) cycle();
        RST = 1'b1;
        cycle();
        rel_c = cyc;
        RST = 1'b0;
        repeat (20) cycle();
        chk("rstmid_count", step_count - s0, 32'd1);
        chk("rstmid_delay", last_step_cyc - rel_c, 32'd11);
        Btn = 1'b0;
        repeat (20) cycle();

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            Sel = 2'($urandom_range(0, 3));
            PCOut = $urandom; PCIn = $urandom; Rs = 5'($urandom); RsData = $urandom;
            Rt = 5'($urandom); RtData = $urandom; ALUResult = $urandom; DB = $urandom;
            Btn = 1'($urandom);
            RST = ($urandom_range(0, 59) == 0);
            repeat ($urandom_range(1, 12)) cycle();
            RST = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
